// File: rtl/key_expand_seq.sv
// ---------------------------------------------------------------------------
// key_expand_seq
//   AES-128 key-schedule sequencer. Loads a 128-bit cipher key on start and
//   emits round keys 0..NUM_ROUNDS one per accepted transfer on a
//   valid/ready stream. The AES g-function (RotWord, SubWord, Rcon) is
//   computed combinationally by keyround() and folded into the next key.
//
//   Optional feature macro: KEY_STORE_EN
//     defined   : 11x128 register store written with each transferred key.
//                 rd_data = store[rd_idx] (combinational), 0 for
//                 rd_idx > NUM_ROUNDS. The store is cleared only by rst.
//     undefined : no store; rd_data is tied to 0.
//
//   Ports
//     clk        in   1    clock, rising edge
//     rst        in   1    asynchronous reset, active-high
//     start      in   1    load key_in and begin expansion (IDLE only)
//     key_in     in   128  cipher key, FIPS byte k at [8k+7:8k]
//     busy       out  1    high in EMIT and DONE
//     rk_valid   out  1    rk_data / rk_round valid
//     rk_ready   in   1    downstream accepts current round key
//     rk_data    out  128  round key, same byte order as key_in
//     rk_round   out  4    round index of rk_data
//     done       out  1    one-cycle pulse after the last round transfers
//     rd_idx     in   4    stored-key read index
//     rd_data    out  128  stored round key
//     dbg_state  out  2    FSM state (0 IDLE, 1 EMIT, 2 DONE)
//
//   Handshake: a transfer happens on a rising edge where rk_valid and
//   rk_ready are both high. While rk_valid is high and rk_ready is low,
//   rk_data and rk_round hold; rk_valid never drops without a transfer
//   except on rst.
// ---------------------------------------------------------------------------
module key_expand_seq #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_INIT  = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed algebraically: multiplicative inverse (a^254, which
    // maps 0 to 0) followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        // After k rounds of square-and-multiply r = a^(2^(k+1)-1); 6 rounds give a^127.
        for (int i = 0; i < 6; i++) begin
            r = gmul(r, r);
            r = gmul(r, a);
        end
        r = gmul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // g-function. Bytes are packed with the first FIPS byte in [7:0], so
    // RotWord moves byte [7:0] to [31:24] and Rcon lands in [7:0].
    function automatic logic [63:0] keyround(input logic [63:0] in_w, input logic [7:0] count);
        logic [31:0] rot;
        logic [31:0] sub;
        rot = {in_w[7:0], in_w[31:8]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        return {in_w[63:32], sub ^ {24'h0, count}};
    endfunction

    logic [1:0]   state;
    logic [7:0]   rcon;
    logic [63:0]  kr_out;
    logic [31:0]  g;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_key;
    logic         xfer;

    assign xfer     = (state == EMIT) && rk_ready;
    assign rk_valid = (state == EMIT);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        kr_out   = keyround({32'h0, rk_data[127:96]}, rcon);
        g        = kr_out[31:0];
        nw0      = rk_data[31:0]  ^ g;
        nw1      = rk_data[63:32] ^ nw0;
        nw2      = rk_data[95:64] ^ nw1;
        nw3      = rk_data[127:96] ^ nw2;
        next_key = {nw3, nw2, nw1, nw0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rk_data  <= '0;
            rk_round <= '0;
            rcon     <= RCON_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= EMIT;
                        rk_data  <= key_in;
                        rk_round <= '0;
                        rcon     <= RCON_INIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rk_round == LAST) begin
                            state <= DONE;
                        end else begin
                            rk_data  <= next_key;
                            rk_round <= rk_round + 4'd1;
                            rcon     <= xtime(rcon);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_STORE_EN
    logic [127:0] store [0:NUM_ROUNDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
        end else if (xfer) begin
            store[rk_round] <= rk_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx <= LAST) rd_data = store[rd_idx];
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd_idx, xfer};
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_key_expand_seq.sv
module tb_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  key_expand_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .done(done), .rd_idx(rd_idx), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    int i;
    i = b;
    return SBOX_BITS[2047 - 8*i -: 8];
  endfunction

  // Big-endian hex string (FIPS order) -> packed bus with byte 0 at [7:0].
  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[127 - 8*k -: 8];
    return r;
  endfunction

  // Reference: textbook FIPS-197 word expansion on big-endian words.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++)
      w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    exp_q.delete();
    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < 16; k++)
        exp_rk[r][8*k +: 8] = w[4*r + k/4][31 - 8*(k%4) -: 8];
      exp_q.push_back(exp_rk[r]);
    end
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
  // noise: pulse start (with a junk key) mid-EMIT and on the final transfer.
  task automatic run_expansion(input logic [127:0] key, input int mode, input bit noise,
                               input bit chk_vec, input logic [127:0] r1,
                               input logic [127:0] r10, input string tag);
    int idx;
    int cyc;
    bit stalled;
    bit rdy;
    logic [127:0] prev_d;
    logic [3:0] prev_r;
    logic [127:0] exp_d;
    build_model(key);
    @(negedge clk);
    start = 1'b1; key_in = key; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    n_checks++;
    if (rk_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s latency: rk_valid=%b busy=%b, required 1 1", tag, rk_valid, busy);
    else n_pass++;
    idx = 0; cyc = 0; stalled = 1'b0; prev_d = '0; prev_r = '0;
    while (idx <= 10 && cyc < 200) begin
      if (stalled) begin
        n_checks++;
        if (rk_data !== prev_d || rk_round !== prev_r)
          $display("FAIL %s stall_hold: data=%h round=%0d, required %h %0d",
                   tag, rk_data, rk_round, prev_d, prev_r);
        else n_pass++;
      end
      exp_d = exp_q[0];
      n_checks++;
      if (rk_valid !== 1'b1 || rk_data !== exp_d || rk_round !== 4'(idx))
        $display("FAIL %s round_%0d: valid=%b data=%h round=%0d, required 1 %h %0d",
                 tag, idx, rk_valid, rk_data, rk_round, exp_d, idx);
      else n_pass++;
      if (chk_vec && (idx == 1 || idx == 10)) begin
        n_checks++;
        if (rk_data !== ((idx == 1) ? fips(r1) : fips(r10)))
          $display("FAIL %s vector_r%0d: got %h, required %h", tag, idx, rk_data,
                   (idx == 1) ? fips(r1) : fips(r10));
        else n_pass++;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rk_ready = rdy;
      if (noise && (idx == 3 || (idx == 10 && rdy))) begin
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      prev_d = rk_data; prev_r = rk_round;
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; rk_ready = 1'b0;
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) $display("FAIL %s timeout: %0d rounds after %0d cycles", tag, idx, cyc);
    else n_pass++;
    if (mode == 0) begin
      n_checks++;
      if (cyc !== 11) $display("FAIL %s consecutive: %0d cycles, required 11", tag, cyc);
      else n_pass++;
    end
    n_checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s done_pulse: done=%b valid=%b busy=%b, required 1 0 1",
               tag, done, rk_valid, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s back_idle: done=%b valid=%b busy=%b, required 0 0 0",
               tag, done, rk_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0; rd_idx = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_data !== '0 ||
        rk_round !== 4'd0 || rd_data !== '0)
      $display("FAIL reset_values: valid=%b busy=%b done=%b data=%h round=%0d rd=%h, required all 0",
               rk_valid, busy, done, rk_data, rk_round, rd_data);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", rk_valid, busy);
    else n_pass++;
  endtask

  task automatic test_fips_vector();
    run_expansion(fips(FIPS_KEY), 0, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "fips");
  endtask

  task automatic test_key_store();
`ifdef KEY_STORE_EN
    build_model(fips(FIPS_KEY));
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      n_checks++;
      if (rd_data !== ((i <= 10) ? exp_rk[i] : 128'h0))
        $display("FAIL store_idx_%0d: got %h, required %h", i, rd_data,
                 (i <= 10) ? exp_rk[i] : 128'h0);
      else n_pass++;
    end
    rd_idx = 4'd10; #1;
    n_checks++;
    if (rd_data !== fips(FIPS_R10)) $display("FAIL store_r10: got %h, required %h", rd_data, fips(FIPS_R10));
    else n_pass++;
    rd_idx = 4'd0; #1;
    n_checks++;
    if (rd_data !== fips(FIPS_KEY)) $display("FAIL store_r0: got %h, required %h", rd_data, fips(FIPS_KEY));
    else n_pass++;
`else
    for (int i = 0; i < 6; i++) begin
      rd_idx = 4'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (rd_data !== 128'h0) $display("FAIL rd_data_tied: got %h, required 0", rd_data);
      else n_pass++;
    end
`endif
    rd_idx = 4'd0;
  endtask

  task automatic test_backpressure();
    run_expansion(fips(FIPS_KEY), 1, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "backpressure");
  endtask

  task automatic test_zero_key();
    run_expansion(128'h0, 0, 1'b0, 1'b1, ZERO_R1, ZERO_R10, "zero_key");
  endtask

  task automatic test_start_ignored();
    run_expansion({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 1'b0, '0, '0, "start_ignored");
    run_expansion(fips(FIPS_KEY), 0, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "restart");
  endtask

  task automatic test_abort_reset();
    @(negedge clk);
    start = 1'b1; key_in = fips(FIPS_KEY); rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (rk_round !== 4'd5 || rk_valid !== 1'b1)
      $display("FAIL abort_pre: round=%0d valid=%b, required 5 1", rk_round, rk_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_data !== '0 || rk_round !== 4'd0 || done !== 1'b0)
      $display("FAIL abort_reset: valid=%b busy=%b data=%h round=%0d done=%b, required all 0",
               rk_valid, busy, rk_data, rk_round, done);
    else n_pass++;
    rk_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_expansion(fips(FIPS_KEY), 2, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "after_abort");
  endtask

  task automatic test_random_keys();
    for (int t = 0; t < 4; t++)
      run_expansion({$urandom, $urandom, $urandom, $urandom}, 2, t[0], 1'b0, '0, '0, "random");
  endtask

  initial begin
    test_reset();
    test_fips_vector();
    test_key_store();
    test_backpressure();
    test_zero_key();
    test_start_ignored();
    test_abort_reset();
    test_random_keys();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
